// File: rtl/display_pkg.sv
// Purpose: default constants shared by the display bank and its scan engine.
// Ports: none (package only).
package display_pkg;

  localparam int unsigned DEF_N         = 4;
  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_SCAN_DIV  = 4;
  localparam int unsigned DEF_BLINK_DIV = 16;
  localparam int unsigned DEF_BLANK     = 0;

  // Counter width that still works for a divider of 1.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/display_scan.sv
// Purpose: multiplexed-display scan engine. Steps the active digit every
//   SCAN_DIV cycles, runs the blink phase, and drives the active digit's value.
// Ports:
//   clk, Reset       clock and synchronous active-high reset
//   disp[N*W]        registered channel values, channel i at [i*W +: W]
//   blink_mask[N]    per-channel blink enable
//   scan_sel[N]      one-hot active-digit select (combinational decode of idx)
//   scan_data[W]     value for the active digit, BLANK during the blink-off phase
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned   N         = DEF_N,
  parameter int unsigned   W         = DEF_W,
  parameter int unsigned   SCAN_DIV  = DEF_SCAN_DIV,
  parameter int unsigned   BLINK_DIV = DEF_BLINK_DIV,
  parameter logic [W-1:0]  BLANK     = W'(DEF_BLANK)
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic [N*W-1:0] disp,
  input  logic [N-1:0]   blink_mask,
  output logic [N-1:0]   scan_sel,
  output logic [W-1:0]   scan_data
);

  localparam int unsigned SCW = cnt_width(SCAN_DIV);
  localparam int unsigned BCW = cnt_width(BLINK_DIV);
  localparam int unsigned IW  = cnt_width(N);

  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           blink_phase_q, blink_phase_d;
  logic           scan_wrap_c;
  logic           blink_wrap_c;

  // Next-state for the scan and blink timebases.
  always_comb begin
    scan_cnt_d    = scan_cnt_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    scan_wrap_c  = (scan_cnt_q == SCW'(SCAN_DIV - 1));
    blink_wrap_c = (blink_cnt_q == BCW'(BLINK_DIV - 1));

    if (scan_wrap_c) begin
      scan_cnt_d = '0;
      // With N=1 the compare is always true, so idx stays 0.
      idx_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      scan_cnt_d = scan_cnt_q + SCW'(1);
    end

    if (blink_wrap_c) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BCW'(1);
    end
  end

  // Timebase registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // One-hot decode of idx and blank mux; no added latency.
  always_comb begin
    scan_sel  = '0;
    scan_data = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        scan_sel[i] = 1'b1;
        scan_data   = (blink_mask[i] && blink_phase_q) ? BLANK : disp[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/display_bank.sv
// Purpose: bank of N display channel registers with edge-detected capture,
//   level-sensitive clear and a scanned multiplexed-display output.
// Ports:
//   clk, Reset       clock and synchronous active-high reset
//   inp[W]           data to capture
//   priem            capture strobe; only its rising edge captures
//   set_mask[N]      channels that capture on a priem rising edge
//   clr_mask[N]      per-channel clear (wins over capture)
//   blink_mask[N]    per-channel blink enable for the scanned output
//   disp[N*W]        registered channel values, channel i at [i*W +: W]
//   loaded[N]        channel holds a captured value
//   scan_sel[N]      one-hot active-digit select
//   scan_data[W]     value driven to the active digit
module display_bank
  import display_pkg::*;
#(
  parameter int unsigned   N         = DEF_N,
  parameter int unsigned   W         = DEF_W,
  parameter int unsigned   SCAN_DIV  = DEF_SCAN_DIV,
  parameter int unsigned   BLINK_DIV = DEF_BLINK_DIV,
  parameter logic [W-1:0]  BLANK     = W'(DEF_BLANK)
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic [W-1:0]   inp,
  input  logic           priem,
  input  logic [N-1:0]   set_mask,
  input  logic [N-1:0]   clr_mask,
  input  logic [N-1:0]   blink_mask,
  output logic [N*W-1:0] disp,
  output logic [N-1:0]   loaded,
  output logic [N-1:0]   scan_sel,
  output logic [W-1:0]   scan_data
);

  logic [N*W-1:0] disp_q, disp_d;
  logic [N-1:0]   loaded_q, loaded_d;
  logic           priem_d_q, priem_d_d;
  logic           rise_c;

  // Edge detect and per-channel capture/clear; clear takes priority.
  always_comb begin
    disp_d    = disp_q;
    loaded_d  = loaded_q;
    priem_d_d = priem;
    rise_c    = priem & ~priem_d_q;
    for (int i = 0; i < N; i++) begin
      if (clr_mask[i]) begin
        disp_d[i*W +: W] = '0;
        loaded_d[i]      = 1'b0;
      end else if (rise_c && set_mask[i]) begin
        disp_d[i*W +: W] = inp;
        loaded_d[i]      = 1'b1;
      end
    end
  end

  // Channel registers; priem_d clears in reset so a high strobe right
  // after reset counts as a rising edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      disp_q    <= '0;
      loaded_q  <= '0;
      priem_d_q <= 1'b0;
    end else begin
      disp_q    <= disp_d;
      loaded_q  <= loaded_d;
      priem_d_q <= priem_d_d;
    end
  end

  assign disp   = disp_q;
  assign loaded = loaded_q;

  display_scan #(
    .N         (N),
    .W         (W),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV),
    .BLANK     (BLANK)
  ) u_scan (
    .clk        (clk),
    .Reset      (Reset),
    .disp       (disp_q),
    .blink_mask (blink_mask),
    .scan_sel   (scan_sel),
    .scan_data  (scan_data)
  );

endmodule

// File: tb/tb_display_bank.sv
module tb_display_bank;

  localparam int N = 4;
  localparam int W = 8;
  localparam int SD = 4;
  localparam int BD = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] inp;
  logic         priem;
  logic [N-1:0] set_mask, clr_mask, blink_mask;
  logic [N*W-1:0] disp;
  logic [N-1:0] loaded, scan_sel;
  logic [W-1:0] scan_data;

  int total = 0;
  int bad   = 0;

  // Reference model: channel contents plus a cycle count since reset.
  logic [W-1:0] m_disp [N];
  logic [N-1:0] m_loaded;
  logic         m_prev;
  int           t;

  always #5 clk = ~clk;

  display_bank #(.N(N), .W(W), .SCAN_DIV(SD), .BLINK_DIV(BD), .BLANK(8'h00)) dut (
    .clk(clk), .Reset(rst), .inp(inp), .priem(priem), .set_mask(set_mask),
    .clr_mask(clr_mask), .blink_mask(blink_mask), .disp(disp), .loaded(loaded),
    .scan_sel(scan_sel), .scan_data(scan_data)
  );

  function automatic int e_idx();
    return (t / SD) % N;
  endfunction

  function automatic logic [N-1:0] e_sel();
    return N'(1 << e_idx());
  endfunction

  function automatic logic [W-1:0] e_data();
    if (blink_mask[e_idx()] && ((t / BD) % 2 == 1)) return '0;
    return m_disp[e_idx()];
  endfunction

  function automatic logic [N*W-1:0] e_disp();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = m_disp[i];
    return v;
  endfunction

  // One clock: model follows the inputs applied before the edge; ends on negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_disp[i] = '0;
      m_loaded = '0;
      m_prev   = 1'b0;
      t        = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr_mask[i]) begin
          m_disp[i] = '0; m_loaded[i] = 1'b0;
        end else if (priem && !m_prev && set_mask[i]) begin
          m_disp[i] = inp; m_loaded[i] = 1'b1;
        end
      end
      m_prev = priem;
      t++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    priem = 0; set_mask = '0; clr_mask = '0; inp = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); blink_mask = '0;
    priem = 1; set_mask = '1; inp = 8'hA5; clr_mask = '0;
    tick(); tick();
    total++; if (disp !== '0) begin bad++; $display("FAIL reset_disp got=%h want=0", disp); end
    total++; if (loaded !== '0) begin bad++; $display("FAIL reset_loaded got=%b want=0000", loaded); end
    total++; if (scan_sel !== 4'b0001) begin bad++; $display("FAIL reset_sel got=%b want=0001", scan_sel); end
    total++; if (scan_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=00", scan_data); end
    // priem already high as reset falls: first cycle counts as a rising edge
    rst = 0; set_mask = 4'b0100; inp = 8'h3C;
    tick();
    total++; if (disp[2*W +: W] !== 8'h3C || loaded !== 4'b0100) begin
      bad++; $display("FAIL reset_first_rise got=%h/%b want=3c/0100", disp[2*W +: W], loaded); end
    idle_inputs(); tick();
  endtask

  task automatic test_capture();
    do_reset();
    inp = 8'd46; set_mask = 4'b0011; priem = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 5) begin inp = 8'd99; set_mask = 4'b1111; end
      total++;
      if (disp !== e_disp() || disp !== {8'd0, 8'd0, 8'd46, 8'd46} || loaded !== 4'b0011) begin
        bad++; $display("FAIL capture c=%0d got=%h/%b want=00002e2e/0011", c, disp, loaded); end
    end
    priem = 0; set_mask = '0; tick();
  endtask

  task automatic test_clear();
    clr_mask = 4'b0001; tick(); clr_mask = '0; tick();
    total++;
    if (disp[0 +: W] !== 8'd0 || disp[W +: W] !== 8'd46 || loaded !== 4'b0010) begin
      bad++; $display("FAIL clear got=%h/%b want=..2e00/0010", disp, loaded); end
  endtask

  task automatic test_simultaneous();
    inp = 8'd7; set_mask = 4'b0001; clr_mask = 4'b0001; priem = 1;
    tick();
    idle_inputs(); tick();
    total++;
    if (disp[0 +: W] !== 8'd0 || loaded[0] !== 1'b0 || disp !== e_disp()) begin
      bad++; $display("FAIL simultaneous got=%h/%b want=disp0=00 loaded0=0", disp, loaded); end
  endtask

  task automatic test_scan();
    do_reset(); blink_mask = '0;
    inp = 8'h11; set_mask = 4'b1010; priem = 1;
    for (int c = 0; c <= 16; c++) begin
      total++;
      if (scan_sel !== N'(1 << ((c / 4) % 4)) || scan_data !== e_data()) begin
        bad++; $display("FAIL scan c=%0d got=%b/%h want=%b/%h", c, scan_sel, scan_data,
                        N'(1 << ((c / 4) % 4)), e_data()); end
      tick();
      priem = 0;
    end
    set_mask = '0;
  endtask

  task automatic test_blink();
    do_reset();
    inp = 8'd46; set_mask = 4'b0010; priem = 1; blink_mask = 4'b0010;
    tick(); idle_inputs();
    while (t < 64) begin
      if (scan_sel == 4'b0010) begin
        total++;
        if (scan_data !== (((t / 16) % 2 == 1) ? 8'd0 : 8'd46)) begin
          bad++; $display("FAIL blink t=%0d got=%h want=%h", t, scan_data,
                          (((t / 16) % 2 == 1) ? 8'd0 : 8'd46)); end
      end
      if (disp[W +: W] !== 8'd46) begin
        total++; bad++; $display("FAIL blink_disp t=%0d got=%h want=2e", t, disp[W +: W]); end
      tick();
    end
    total++;
    if (disp[W +: W] !== 8'd46) begin bad++; $display("FAIL blink_hold got=%h want=2e", disp[W +: W]); end
    blink_mask = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    inp = 8'h5A; set_mask = 4'b1111; priem = 1;
    tick(); idle_inputs();
    while (scan_sel != 4'b0100 && t < 40) tick();
    total++;
    if (loaded !== 4'b1111 || scan_sel !== 4'b0100) begin
      bad++; $display("FAIL midrst_pre got=%b/%b want=1111/0100", loaded, scan_sel); end
    rst = 1; clr_mask = 4'b0011; priem = 1; set_mask = '1; tick(); rst = 0; idle_inputs();
    total++;
    if (disp !== '0 || loaded !== '0 || scan_sel !== 4'b0001) begin
      bad++; $display("FAIL midrst got=%h/%b/%b want=0/0000/0001", disp, loaded, scan_sel); end
    for (int c = 1; c <= 20; c++) begin
      tick();
      total++;
      if (scan_sel !== N'(1 << ((c / 4) % 4)) || scan_data !== e_data()) begin
        bad++; $display("FAIL midrst_restart c=%0d got=%b/%h want=%b/%h", c, scan_sel,
                        scan_data, N'(1 << ((c / 4) % 4)), e_data()); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      priem      = $urandom_range(0, 1);
      inp        = W'($urandom);
      set_mask   = N'($urandom);
      clr_mask   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      blink_mask = N'($urandom);
      tick();
      total++;
      if (disp !== e_disp() || loaded !== m_loaded || scan_sel !== e_sel() ||
          scan_data !== e_data()) begin
        bad++;
        $display("FAIL random c=%0d got=%h/%b/%b/%h want=%h/%b/%b/%h", c, disp, loaded,
                 scan_sel, scan_data, e_disp(), m_loaded, e_sel(), e_data());
      end
    end
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_disp[i] = '0;
    m_loaded = '0; m_prev = 0; t = 0;
    rst = 1; blink_mask = '0; idle_inputs();
    @(negedge clk);
    test_reset();
    test_capture();
    test_clear();
    test_simultaneous();
    test_scan();
    test_blink();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_bank.md
DISPLAY_BANK -- requirements
Module: display_bank

Interface
REQ-001 The block SHALL have parameter N, default 4, channel count (1..16).
REQ-002 The block SHALL have parameter W, default 8, channel data width.
REQ-003 The block SHALL have parameter SCAN_DIV, default 4, clock cycles per scanned digit (>=1).
REQ-004 The block SHALL have parameter BLINK_DIV, default 16, clock cycles per blink half-period (>=1).
REQ-005 The block SHALL have parameter BLANK, default all-zero W-bit, the value shown for a blanked digit.
REQ-006 The block SHALL have port clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-008 The block SHALL have port inp  in  W  data to capture.
REQ-009 The block SHALL have port priem  in  1  capture strobe (edge-detected).
REQ-010 The block SHALL have port set_mask  in  N  channels that capture on a priem rising edge.
REQ-011 The block SHALL have port clr_mask  in  N  per-channel clear, level-sensitive.
REQ-012 The block SHALL have port blink_mask  in  N  per-channel blink enable.
REQ-013 The block SHALL have port disp  out  N x W  registered channel values, unaffected by blink.
REQ-014 The block SHALL have port loaded  out  N  channel holds a captured value.
REQ-015 The block SHALL have port scan_sel  out  N  one-hot active-digit select.
REQ-016 The block SHALL have port scan_data  out  W  value driven to the active digit.

Function
REQ-017 The block SHALL register priem into priem_d; a rising edge SHALL be priem=1 while priem_d=0.
REQ-018 On a rising edge, each channel i with set_mask[i]=1 SHALL load inp into disp[i] and set loaded[i] at that clock edge; the new value SHALL be visible the following cycle.
REQ-019 While priem stays high, no further capture SHALL occur, even if inp or set_mask change.
REQ-020 clr_mask[i]=1 SHALL set disp[i] to 0 and loaded[i] to 0 at the next edge.
REQ-021 If capture and clear hit the same channel in the same cycle, clear SHALL win.
REQ-022 Channels with neither capture nor clear SHALL hold their value.
REQ-023 A scan counter SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL wrap to 0 and advance the digit index idx, with idx wrapping from N-1 to 0.
REQ-024 scan_sel SHALL be a combinational one-hot decode of idx.
REQ-025 A blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap.
REQ-026 scan_data SHALL equal BLANK when blink_mask[idx]=1 and blink_phase=1; otherwise it SHALL equal disp[idx].
REQ-027 scan_data SHALL be combinational from registered state and blink_mask, with no added latency.
REQ-028 When N=1, idx SHALL stay 0 and scan_sel SHALL be constantly 1.

Reset
REQ-029 While Reset=1, the block SHALL force disp=0, loaded=0, priem_d=0, idx=0, scan counter=0, blink counter=0 and blink_phase=0.
REQ-030 The outputs during and after reset SHALL be scan_sel = one-hot bit 0 and scan_data = 0.
REQ-031 Reset SHALL override capture and clear in the same cycle.
REQ-032 If priem=1 on the first cycle after Reset falls, that cycle SHALL count as a rising edge.

Structure
REQ-033 Package display_pkg SHALL hold the default constants for N, W, SCAN_DIV, BLINK_DIV and BLANK.
REQ-034 The scan counter, idx, blink counter, one-hot decode and blank mux SHALL live in one sub-module, display_scan; the channel registers and edge detect SHALL stay in display_bank.

Verification (N=4, W=8, SCAN_DIV=4, BLINK_DIV=16)
REQ-035 Bench SHALL cover capture: after reset, drive inp=46, set_mask=0011 and a priem rise held 20 cycles -> disp[0]=disp[1]=46, disp[2]=disp[3]=0, loaded=0011; changing inp to 99 mid-hold -> no change.
REQ-036 Bench SHALL cover clear: clr_mask=0001 for 1 cycle after the capture scenario -> disp[0]=0, loaded=0010, disp[1]=46.
REQ-037 Bench SHALL cover simultaneous events: a priem rise with set_mask=0001, clr_mask=0001 and inp=7 -> disp[0]=0, loaded[0]=0.
REQ-038 Bench SHALL cover scan: from reset, scan_sel=0001 for cycles 0-3, then 0010, 0100, 1000, and 0001 again at cycle 16; scan_data=disp[idx] at every cycle.
REQ-039 Bench SHALL cover blink: disp[1]=46 and blink_mask=0010 -> while scan_sel=0010, scan_data=46 in cycles 0-15 and 0 in cycles 16-31; disp[1] stays 46 throughout.
REQ-040 Bench SHALL cover mid-operation reset: loaded=1111 at idx=2 and a 1-cycle Reset pulse -> all disp=0, loaded=0000, scan_sel=0001, and both counters restart from 0.
